// File: rtl/ray_aabb_pkg.sv
// Shared definitions for the Ray_AABB accuracy monitor.
// Contents: FSM state encodings, the default counter width, and a
// saturating increment used by every counter in the monitor.
package ray_aabb_pkg;

  localparam int unsigned CNT_W_DEF = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Increment that holds at max_val instead of wrapping (counters up to 32 bits).
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/ray_aabb_golden_delay.sv
// LATENCY-deep shift line carrying {valid, golden} from issue to compare.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low clear (all valid bits 0)
//   vld_i, gold_i  : entry shifted in every cycle
//   tap_vld_o      : valid bit of the oldest stage (registered)
//   tap_gold_o     : golden bits of the oldest stage (registered)
//   any_vld_o_c    : OR of all valid bits, used to leave DRAIN
module ray_aabb_golden_delay #(
  parameter int unsigned LATENCY = 42,
  parameter int unsigned NUM_CH  = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              vld_i,
  input  logic [NUM_CH-1:0] gold_i,
  output logic              tap_vld_o,
  output logic [NUM_CH-1:0] tap_gold_o,
  output logic              any_vld_o_c
);

  logic [LATENCY-1:0] vld_q;
  logic [NUM_CH-1:0]  gold_q [LATENCY];

  // Shift every cycle; golden bits of invalid entries are don't-care.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int k = 0; k < int'(LATENCY); k++) gold_q[k] <= '0;
    end else begin
      vld_q[0]  <= vld_i;
      gold_q[0] <= gold_i;
      for (int k = 1; k < int'(LATENCY); k++) begin
        vld_q[k]  <= vld_q[k-1];
        gold_q[k] <= gold_q[k-1];
      end
    end
  end

  assign tap_vld_o   = vld_q[LATENCY-1];
  assign tap_gold_o  = gold_q[LATENCY-1];
  assign any_vld_o_c = |vld_q;

endmodule

// File: rtl/ray_aabb_err_monitor.sv
// On-chip accuracy monitor for Ray_AABB pipelines. Golden hit bits are
// delayed by LATENCY cycles and compared against the DUT hit_miss; Type1
// (golden hit, DUT miss) and Type2 (golden miss, DUT hit) errors are
// counted per lane with saturating counters.
// Ports:
//   clk, rst              : clock, asynchronous active-low reset
//   start                 : begins a run (honoured in IDLE/DONE only)
//   issue_valid, golden   : vector issue and its golden result per lane
//   hit_miss              : DUT result per lane, LATENCY cycles after issue
//   type1_err, type2_err  : per-lane counters, lane i at [i*CNT_W +: CNT_W]
//   tested_cnt            : number of compared vectors
//   mismatch              : one-cycle per-lane error pulse
//   busy, done            : RUN/DRAIN and DONE indications
// Optional macro RAABB_ERR_FIRST_IDX_EN adds first_err_idx / first_err_vld,
// capturing each lane's first failing vector index of a run.
module ray_aabb_err_monitor
  import ray_aabb_pkg::*;
#(
  parameter int unsigned LATENCY   = 42,
  parameter int unsigned NUM_CH    = 1,
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned NUM_TESTS = 10000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    issue_valid,
  input  logic [NUM_CH-1:0]       golden,
  input  logic [NUM_CH-1:0]       hit_miss,
  output logic [NUM_CH*CNT_W-1:0] type1_err,
  output logic [NUM_CH*CNT_W-1:0] type2_err,
  output logic [CNT_W-1:0]        tested_cnt,
  output logic [NUM_CH-1:0]       mismatch,
  output logic                    busy,
  output logic                    done
`ifdef RAABB_ERR_FIRST_IDX_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] first_err_idx,
  output logic [NUM_CH-1:0]       first_err_vld
`endif
);

  localparam int unsigned       ISS_W    = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1;
  localparam logic [ISS_W-1:0]  ISS_LAST = ISS_W'(NUM_TESTS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(32'(v), 32'(CNT_MAX)));
  endfunction

  logic [1:0]              state_q, state_d;
  logic [ISS_W-1:0]        iss_q, iss_d;
  logic [NUM_CH*CNT_W-1:0] t1_q, t1_d, t2_q, t2_d;
  logic [CNT_W-1:0]        tst_q, tst_d;
  logic [NUM_CH-1:0]       mm_q, mm_d;
  logic                    busy_q, done_q;
  logic                    shift_vld_c, start_run_c;
  logic                    tap_vld;
  logic [NUM_CH-1:0]       tap_gold;
  logic                    any_vld_c;
`ifdef RAABB_ERR_FIRST_IDX_EN
  logic [NUM_CH*CNT_W-1:0] fe_idx_q, fe_idx_d;
  logic [NUM_CH-1:0]       fe_vld_q, fe_vld_d;
`endif

  ray_aabb_golden_delay #(
    .LATENCY (LATENCY),
    .NUM_CH  (NUM_CH)
  ) u_delay (
    .clk_i       (clk),
    .rst_ni      (rst),
    .vld_i       (shift_vld_c),
    .gold_i      (golden),
    .tap_vld_o   (tap_vld),
    .tap_gold_o  (tap_gold),
    .any_vld_o_c (any_vld_c)
  );

  // Next-state, issue accounting and compare stage.
  always_comb begin
    state_d     = state_q;
    iss_d       = iss_q;
    t1_d        = t1_q;
    t2_d        = t2_q;
    tst_d       = tst_q;
    mm_d        = '0;
    shift_vld_c = 1'b0;
    start_run_c = 1'b0;
`ifdef RAABB_ERR_FIRST_IDX_EN
    fe_idx_d    = fe_idx_q;
    fe_vld_d    = fe_vld_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_RUN;
          start_run_c = 1'b1;
        end
      end
      ST_RUN: begin
        if (issue_valid) begin
          shift_vld_c = 1'b1;
          if (iss_q == ISS_LAST) state_d = ST_DRAIN;
          else                   iss_d   = iss_q + ISS_W'(1);
        end
      end
      ST_DRAIN: begin
        if (!any_vld_c) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    // The delay line is empty in IDLE/DONE, so a run start never races a compare.
    if (start_run_c) begin
      iss_d = '0;
      t1_d  = '0;
      t2_d  = '0;
      tst_d = '0;
`ifdef RAABB_ERR_FIRST_IDX_EN
      fe_idx_d = '0;
      fe_vld_d = '0;
`endif
    end else if (tap_vld) begin
      tst_d = inc(tst_q);
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (tap_gold[i] && !hit_miss[i]) begin
          t1_d[i*CNT_W +: CNT_W] = inc(t1_q[i*CNT_W +: CNT_W]);
          mm_d[i]                = 1'b1;
        end else if (!tap_gold[i] && hit_miss[i]) begin
          t2_d[i*CNT_W +: CNT_W] = inc(t2_q[i*CNT_W +: CNT_W]);
          mm_d[i]                = 1'b1;
        end
`ifdef RAABB_ERR_FIRST_IDX_EN
        if (mm_d[i] && !fe_vld_q[i]) begin
          fe_vld_d[i]                = 1'b1;
          fe_idx_d[i*CNT_W +: CNT_W] = tst_q;
        end
`endif
      end
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      iss_q    <= '0;
      t1_q     <= '0;
      t2_q     <= '0;
      tst_q    <= '0;
      mm_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef RAABB_ERR_FIRST_IDX_EN
      fe_idx_q <= '0;
      fe_vld_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      iss_q    <= iss_d;
      t1_q     <= t1_d;
      t2_q     <= t2_d;
      tst_q    <= tst_d;
      mm_q     <= mm_d;
      busy_q   <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_q   <= (state_d == ST_DONE);
`ifdef RAABB_ERR_FIRST_IDX_EN
      fe_idx_q <= fe_idx_d;
      fe_vld_q <= fe_vld_d;
`endif
    end
  end

  assign type1_err  = t1_q;
  assign type2_err  = t2_q;
  assign tested_cnt = tst_q;
  assign mismatch   = mm_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifdef RAABB_ERR_FIRST_IDX_EN
  assign first_err_idx = fe_idx_q;
  assign first_err_vld = fe_vld_q;
`endif

endmodule
